// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared timing record, standard modes and line/frame total helper
package vga_timing_pkg;

  localparam int TIMING_W = 11;
  localparam int CALC_W   = 16;

  typedef struct packed {
    logic [TIMING_W-1:0] h_active;
    logic [TIMING_W-1:0] h_fp;
    logic [TIMING_W-1:0] h_sync;
    logic [TIMING_W-1:0] h_bp;
    logic [TIMING_W-1:0] v_active;
    logic [TIMING_W-1:0] v_fp;
    logic [TIMING_W-1:0] v_sync;
    logic [TIMING_W-1:0] v_bp;
  } timing_t;

  localparam timing_t TIMING_640x480_60 = '{
    h_active: 11'd640, h_fp: 11'd16, h_sync: 11'd96,  h_bp: 11'd48,
    v_active: 11'd480, v_fp: 11'd10, v_sync: 11'd2,   v_bp: 11'd33
  };

  localparam timing_t TIMING_800x600_60 = '{
    h_active: 11'd800, h_fp: 11'd40, h_sync: 11'd128, h_bp: 11'd88,
    v_active: 11'd600, v_fp: 11'd1,  v_sync: 11'd4,   v_bp: 11'd23
  };

  // Callers pass zero-extended fields so one helper serves any COORD_W up to 14.
  function automatic logic [CALC_W-1:0] line_total(input logic [CALC_W-1:0] active,
                                                   input logic [CALC_W-1:0] fp,
                                                   input logic [CALC_W-1:0] sync,
                                                   input logic [CALC_W-1:0] bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - ce-qualified shift register; depth 0 degenerates to a wire
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - programmable VGA timing generator, new timing taken only at frame wrap
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int PIPE_DELAY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [COORD_W-1:0] cfg_h_active,
  input  logic [COORD_W-1:0] cfg_h_fp,
  input  logic [COORD_W-1:0] cfg_h_sync,
  input  logic [COORD_W-1:0] cfg_h_bp,
  input  logic [COORD_W-1:0] cfg_v_active,
  input  logic [COORD_W-1:0] cfg_v_fp,
  input  logic [COORD_W-1:0] cfg_v_sync,
  input  logic [COORD_W-1:0] cfg_v_bp,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank
);

  localparam int TW = COORD_W + 2;
  localparam int BW = 6 + 2 * COORD_W;
  localparam int SW = 8 * COORD_W;

  localparam logic [SW-1:0] TIMING_DEFAULT = {
    COORD_W'(H_ACTIVE), COORD_W'(H_FP), COORD_W'(H_SYNC), COORD_W'(H_BP),
    COORD_W'(V_ACTIVE), COORD_W'(V_FP), COORD_W'(V_SYNC), COORD_W'(V_BP)
  };
  localparam logic [BW-1:0] BUS_RST = {~H_SYNC_POL, ~V_SYNC_POL, 4'b0000, {(2*COORD_W){1'b0}}};

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic [SW-1:0]      act_t, pend_t, cfg_bus;
  logic               pend_valid;

  logic [COORD_W-1:0] a_h_act, a_h_fp, a_h_sync, a_h_bp;
  logic [COORD_W-1:0] a_v_act, a_v_fp, a_v_sync, a_v_bp;
  logic [TW-1:0]      h_e, v_e, h_total, v_total;
  logic [TW-1:0]      h_sync_beg, h_sync_end, v_sync_beg, v_sync_end;
  logic               h_wrap, v_wrap, frame_wrap;
  logic               de_d, hs_d, vs_d, ls_d, fs_d, vb_d;
  logic [BW-1:0]      dec_bus, stage_bus, out_bus;

  assign cfg_bus = {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                    cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp};
  assign {a_h_act, a_h_fp, a_h_sync, a_h_bp, a_v_act, a_v_fp, a_v_sync, a_v_bp} = act_t;

  assign h_total    = TW'(line_total(CALC_W'(a_h_act), CALC_W'(a_h_fp), CALC_W'(a_h_sync), CALC_W'(a_h_bp)));
  assign v_total    = TW'(line_total(CALC_W'(a_v_act), CALC_W'(a_v_fp), CALC_W'(a_v_sync), CALC_W'(a_v_bp)));
  assign h_sync_beg = TW'(a_h_act) + TW'(a_h_fp);
  assign h_sync_end = h_sync_beg + TW'(a_h_sync);
  assign v_sync_beg = TW'(a_v_act) + TW'(a_v_fp);
  assign v_sync_end = v_sync_beg + TW'(a_v_sync);

  assign h_e        = TW'(h_cnt);
  assign v_e        = TW'(v_cnt);
  assign h_wrap     = (h_e == h_total - TW'(1));
  assign v_wrap     = (v_e == v_total - TW'(1));
  assign frame_wrap = ce && h_wrap && v_wrap;
  assign cfg_ready  = !pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  // Apply and accept are exclusive: a slot can only be filled while it is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_t      <= TIMING_DEFAULT;
      pend_t     <= '0;
      pend_valid <= 1'b0;
    end else if (frame_wrap && pend_valid) begin
      act_t      <= pend_t;
      pend_valid <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pend_t     <= cfg_bus;
      pend_valid <= 1'b1;
    end
  end

  assign de_d = (h_e < TW'(a_h_act)) && (v_e < TW'(a_v_act));
  assign hs_d = (h_e >= h_sync_beg) && (h_e < h_sync_end);
  assign vs_d = (v_e >= v_sync_beg) && (v_e < v_sync_end);
  assign ls_d = (h_cnt == '0);
  assign fs_d = ls_d && (v_cnt == '0);
  assign vb_d = (v_e >= TW'(a_v_act));

  assign dec_bus = {hs_d ^ ~H_SYNC_POL, vs_d ^ ~V_SYNC_POL, de_d, ls_d, fs_d, vb_d, h_cnt, v_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     stage_bus <= BUS_RST;
    else if (ce) stage_bus <= dec_bus;
  end

  vga_delay_line #(
    .WIDTH  (BW),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL(BUS_RST)
  ) u_delay (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .d  (stage_bus),
    .q  (out_bus)
  );

  assign {hsync, vsync, de, line_start, frame_start, vblank, x, y} = out_bus;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on small hand-sized timings
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int CW = 11;
  typedef logic [6+2*CW-1:0] obs_t;

  logic    clk = 1'b0;
  logic    rst, ce, cfg_valid;
  timing_t cfg;
  logic    cfg_ready0, hsync0, vsync0, de0, line_start0, frame_start0, vblank0;
  logic    cfg_ready1, hsync1, vsync1, de1, line_start1, frame_start1, vblank1;
  logic [CW-1:0] x0, y0, x1, y1;

  always #5 clk = ~clk;

  // Hand-computed boundaries: index 0 = instance defaults (4/1/2/1, 3/1/1/1), 1 = programmed (5/2/3/2, 4/2/1/1)
  int htot [2] = '{8, 12};
  int hact [2] = '{4, 5};
  int hss  [2] = '{5, 7};
  int hse  [2] = '{7, 10};
  int vtot [2] = '{6, 8};
  int vact [2] = '{3, 4};
  int vss  [2] = '{4, 6};
  int vse  [2] = '{5, 7};
  timing_t tim [2];

  int   n_checks = 0, n_pass = 0;
  obs_t q0[$], q1[$];
  obs_t last_e0, last_e1;
  bit   mon_en = 1'b0;
  int   mh, mv, cur, pidx;
  bit   pend_m;

  obs_t act0, act1;
  assign act0 = {hsync0, vsync0, de0, line_start0, frame_start0, vblank0, x0, y0};
  assign act1 = {hsync1, vsync1, de1, line_start1, frame_start1, vblank1, x1, y1};

  vga_timing_gen #(
    .COORD_W(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(0)
  ) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready0),
    .cfg_h_active(cfg.h_active), .cfg_h_fp(cfg.h_fp), .cfg_h_sync(cfg.h_sync), .cfg_h_bp(cfg.h_bp),
    .cfg_v_active(cfg.v_active), .cfg_v_fp(cfg.v_fp), .cfg_v_sync(cfg.v_sync), .cfg_v_bp(cfg.v_bp),
    .hsync(hsync0), .vsync(vsync0), .de(de0), .x(x0), .y(y0),
    .line_start(line_start0), .frame_start(frame_start0), .vblank(vblank0)
  );

  vga_timing_gen #(
    .COORD_W(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1),
    .cfg_h_active(cfg.h_active), .cfg_h_fp(cfg.h_fp), .cfg_h_sync(cfg.h_sync), .cfg_h_bp(cfg.h_bp),
    .cfg_v_active(cfg.v_active), .cfg_v_fp(cfg.v_fp), .cfg_v_sync(cfg.v_sync), .cfg_v_bp(cfg.v_bp),
    .hsync(hsync1), .vsync(vsync1), .de(de1), .x(x1), .y(y1),
    .line_start(line_start1), .frame_start(frame_start1), .vblank(vblank1)
  );

  function automatic void check(string name, obs_t got, obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got %h required %h", name, $time, got, want);
  endfunction

  function automatic obs_t expect_at(int h, int v, int t, bit hpol, bit vpol);
    logic hs, vs;
    hs = (h >= hss[t]) && (h < hse[t]);
    vs = (v >= vss[t]) && (v < vse[t]);
    return {hpol ? hs : !hs, vpol ? vs : !vs, (h < hact[t]) && (v < vact[t]),
            h == 0, (h == 0) && (v == 0), v >= vact[t], CW'(h), CW'(v)};
  endfunction

  function automatic obs_t rst_obs(bit hpol, bit vpol);
    return {!hpol, !vpol, 4'b0000, {(2*CW){1'b0}}};
  endfunction

  initial begin : monitor
    bit ce_s, live;
    forever begin
      @(posedge clk);
      ce_s = ce;
      live = mon_en && !rst;
      #1;
      if (live && ce_s) begin
        if (q0.size() == 0) begin
          n_checks++;
          $display("FAIL dut0_queue @%0t: got empty queue required an entry", $time);
        end else begin
          last_e0 = q0.pop_front();
          check("dut0_out", act0, last_e0);
        end
        if (q1.size() == 0) begin
          n_checks++;
          $display("FAIL dut1_queue @%0t: got empty queue required an entry", $time);
        end else begin
          last_e1 = q1.pop_front();
          check("dut1_out", act1, last_e1);
        end
      end else if (live) begin
        check("dut0_hold", act0, last_e0);
        check("dut1_hold", act1, last_e1);
      end
    end
  end

  // One clock of stimulus; the model advances exactly as the DUT should on the coming edge.
  task automatic tick(input bit ce_v, input bit offer, input int tidx);
    bit accept;
    @(negedge clk);
    check("cfg_ready0", obs_t'(cfg_ready0), obs_t'(!pend_m));
    check("cfg_ready1", obs_t'(cfg_ready1), obs_t'(!pend_m));
    ce        = ce_v;
    cfg_valid = offer;
    if (offer) cfg = tim[tidx];
    accept = offer && !pend_m;
    if (ce_v) begin
      q0.push_back(expect_at(mh, mv, cur, 1'b0, 1'b0));
      q1.push_back(expect_at(mh, mv, cur, 1'b1, 1'b1));
      if (mh == htot[cur] - 1) begin
        mh = 0;
        if (mv == vtot[cur] - 1) begin
          mv = 0;
          if (pend_m) begin
            cur    = pidx;
            pend_m = 1'b0;
          end
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
    if (accept) begin
      pend_m = 1'b1;
      pidx   = tidx;
    end
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    ce        = 1'b0;
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_dut0", act0, rst_obs(1'b0, 1'b0));
    check("rst_dut1", act1, rst_obs(1'b1, 1'b1));
    check("rst_cfg_ready", obs_t'({cfg_ready1, cfg_ready0}), obs_t'(2'b11));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    repeat (3) q1.push_back(rst_obs(1'b1, 1'b1));
    last_e0 = rst_obs(1'b0, 1'b0);
    last_e1 = rst_obs(1'b1, 1'b1);
    mh = 0; mv = 0; cur = 0; pidx = 0;
    pend_m = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b0; ce = 1'b0; cfg_valid = 1'b0; cfg = '0;
    tim[0] = '{h_active: 11'd4, h_fp: 11'd1, h_sync: 11'd2, h_bp: 11'd1,
               v_active: 11'd3, v_fp: 11'd1, v_sync: 11'd1, v_bp: 11'd1};
    tim[1] = '{h_active: 11'd5, h_fp: 11'd2, h_sync: 11'd3, h_bp: 11'd2,
               v_active: 11'd4, v_fp: 11'd2, v_sync: 11'd1, v_bp: 11'd1};
    do_reset();

    repeat (96) tick(1'b1, 1'b0, 0);
    repeat (48) begin
      tick(1'b1, 1'b0, 0);
      repeat (3) tick(1'b0, 1'b0, 0);
    end

    while (!(mh == 2 && mv == 1)) tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 1);
    repeat (240) tick(1'b1, 1'b0, 0);

    // Offer lands on the wrap edge itself, so it must wait a whole further frame.
    while (!(mh == htot[cur] - 1 && mv == vtot[cur] - 1)) tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 0);
    repeat (144) tick(1'b1, 1'b0, 0);

    for (int i = 0; i < 100; i++) tick((i % 3) != 2, 1'b0, 0);

    while (!(mh == 3 && mv == 2)) tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 1);
    repeat (3) tick(1'b1, 1'b0, 0);
    do_reset();
    repeat (120) tick(1'b1, 1'b0, 0);

    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    check("q0_drained", obs_t'(q0.size()), obs_t'(0));
    check("q1_in_pipe", obs_t'(q1.size()), obs_t'(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor of the team's fixed 640x480 VGA timing generator. Generates hsync/vsync/de, pixel coordinates and frame/line strobes from one system clock qualified by a pixel clock-enable. Adds runtime-programmable timing through a valid/ready config port, applied glitch-free at frame boundaries. Adds configurable sync polarity and an output delay line so sync/de stay aligned with downstream pixel pipelines.

Parameters:
COORD_W, 11, width of x/y counters and config fields
H_ACTIVE, 640, reset-default active pixels per line
H_FP, 16, reset-default horizontal front porch
H_SYNC, 96, reset-default hsync width
H_BP, 48, reset-default horizontal back porch
V_ACTIVE, 480, reset-default active lines
V_FP, 10, reset-default vertical front porch
V_SYNC, 2, reset-default vsync width
V_BP, 33, reset-default vertical back porch
H_SYNC_POL, 0, 0 = hsync active-low, 1 = active-high
V_SYNC_POL, 0, 0 = vsync active-low, 1 = active-high
PIPE_DELAY, 0, extra ce-qualified register stages on all outputs (0..8)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ce  in  1  pixel enable; timing advances only when high
cfg_valid  in  1  new timing set offered
cfg_ready  out  1  pending slot empty, config accepted
cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  COORD_W each  horizontal timing
cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  COORD_W each  vertical timing
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
de  out  1  data enable (active area)
x  out  COORD_W  horizontal counter of presented pixel
y  out  COORD_W  vertical counter of presented pixel
line_start  out  1  high while presented x == 0
frame_start  out  1  high while presented (x,y) == (0,0)
vblank  out  1  high while presented y >= active lines

Behaviour:
- Reset (async, rst=1): h/v counters 0; active timing = parameter defaults; pending slot empty; cfg_ready=1; de=0; x=y=0; hsync/vsync at inactive level; line_start=frame_start=vblank=0; all delay stages cleared to the same values.
- Line order: active, front porch, sync, back porch. H_TOTAL = active+fp+sync+bp; V_TOTAL likewise. Compute in COORD_W+2 bits; totals must fit COORD_W. Every field >= 1; other values are unsupported and unchecked.
- Counters: on ce=1, h increments; at H_TOTAL-1 wraps to 0 and v increments; v wraps to 0 at V_TOTAL-1 on the same edge. ce=0 freezes counters and all output/delay registers.
- Decode from the current counters (h, v):
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync likewise on v.
  - vblank = v>=V_ACTIVE.
  - Decoded values are registered with x=h, y=v: 1 ce-cycle latency, plus PIPE_DELAY further ce stages, identical for every output.
- Config handshake: transfer on cfg_valid && cfg_ready at a clk edge. This captures all eight fields into the pending slot and drops cfg_ready next cycle. Pending is applied on the ce edge where both counters wrap to (0,0). cfg_ready returns to 1 the following clk cycle.
- A transfer on that same wrap edge is not applied until the next wrap.
- Active timing never changes mid-frame.
- Reset mid-operation discards pending config and restores defaults.

Decomposition:
- Package vga_timing_pkg holds:
  - typedef timing_t: struct of the eight COORD_W fields.
  - Constants TIMING_640x480_60 (defaults above) and TIMING_800x600_60 (800/40/128/88, 600/1/4/23).
  - Function computing totals.
- Sub-module vga_delay_line: ce-qualified shift register of parameter width/depth, depth 0 = wire. Used for the output bundle.

Test Plan:
- Defaults, ce=1, PIPE_DELAY=0:
  - hsync low exactly for x 656..751.
  - vsync low for y 490..491.
  - de count per frame = 307200.
  - frame_start period = 420000 clk.
- ce toggling 1-of-4: identical sequence at one quarter rate; frame_start period = 1680000 clk; no output changes on ce=0 cycles.
- Program 800x600 timing at x=100, y=200:
  - cfg_ready low from next cycle.
  - Old 800x525 frame completes unchanged.
  - Next frame: H_TOTAL 1056, V_TOTAL 628, hsync x 840..967.
  - cfg_ready high 1 cycle after the wrap.
- H_SYNC_POL=1, V_SYNC_POL=1: hsync high for x 656..751, low elsewhere, low during reset.
- PIPE_DELAY=3: all outputs shifted 3 ce-cycles relative to PIPE_DELAY=0 run; de/x/hsync remain mutually aligned.
- Assert rst at x=300, y=100 with config pending: immediate reset values; resumes default 640x480 from (0,0); cfg_ready=1.
